// File: rtl/serial_word_assembler_if.sv
// Bundle of serial input and assembled-word output signals for serial_word_assembler.
// The master modport drives the bit stream; the slave modport is the assembler itself.
interface serial_word_assembler_if #(
  parameter int unsigned W = 8
);
  logic         din;
  logic         din_valid;
  logic         dir;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         locked;
  logic         parity_err;

  modport master (
    output din,
    output din_valid,
    output dir,
    input  word_out,
    input  word_valid,
    input  locked,
    input  parity_err
  );

  modport slave (
    input  din,
    input  din_valid,
    input  dir,
    output word_out,
    output word_valid,
    output locked,
    output parity_err
  );
endinterface

// File: rtl/serial_word_assembler.sv
// Hunts for SYNC_PAT in a serial stream, then assembles W payload bits MSB- or LSB-first.
// Define SERIAL_ASM_PARITY_EN to add a trailing even-parity bit per frame.
module serial_word_assembler #(
  parameter int unsigned          W        = 8,
  parameter int unsigned          SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0]  SYNC_PAT = 4'b1011
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  serial_word_assembler_if.slave    io_bus
);

  localparam int unsigned FW = $clog2(SYNC_LEN + 1);
  localparam int unsigned BW = $clog2(W);
  localparam logic [FW-1:0] FillFull = FW'(SYNC_LEN);
  localparam logic [BW-1:0] BitLast  = BW'(W - 1);

`ifdef SERIAL_ASM_PARITY_EN
  typedef enum logic [1:0] {StHunt, StData, StParity} state_e;
`else
  typedef enum logic {StHunt, StData} state_e;
`endif

  state_e              r_state, w_state_nxt;
  logic [SYNC_LEN-1:0] r_win, w_win_nxt;
  logic [FW-1:0]       r_fill, w_fill_nxt;
  logic [BW-1:0]       r_bitcnt, w_bitcnt_nxt;
  logic [W-1:0]        r_sr, w_sr_nxt;
  logic                r_dir, w_dir_nxt;
  logic [W-1:0]        r_word, w_word_nxt;
  logic                r_word_valid, w_word_valid_nxt;
  logic                r_locked, w_locked_nxt;
`ifdef SERIAL_ASM_PARITY_EN
  logic                r_par, w_par_nxt;
  logic                r_parity_err, w_parity_err_nxt;
`endif

  logic [SYNC_LEN-1:0] w_win_shift;
  logic [FW-1:0]       w_fill_inc;
  logic [W-1:0]        w_sr_shift;

  assign w_win_shift = {r_win[SYNC_LEN-2:0], io_bus.din};
  assign w_fill_inc  = (r_fill == FillFull) ? r_fill : r_fill + 1'b1;
  assign w_sr_shift  = r_dir ? {io_bus.din, r_sr[W-1:1]} : {r_sr[W-2:0], io_bus.din};

  always_comb begin
    w_state_nxt      = r_state;
    w_win_nxt        = r_win;
    w_fill_nxt       = r_fill;
    w_bitcnt_nxt     = r_bitcnt;
    w_sr_nxt         = r_sr;
    w_dir_nxt        = r_dir;
    w_word_nxt       = r_word;
    w_word_valid_nxt = 1'b0;
    w_locked_nxt     = r_locked;
`ifdef SERIAL_ASM_PARITY_EN
    w_par_nxt        = r_par;
    w_parity_err_nxt = 1'b0;
`endif
    if (io_bus.din_valid) begin
      unique case (r_state)
        StHunt: begin
          w_win_nxt  = w_win_shift;
          w_fill_nxt = w_fill_inc;
          if (w_fill_inc == FillFull && w_win_shift == SYNC_PAT) begin
            w_state_nxt  = StData;
            w_bitcnt_nxt = '0;
            w_dir_nxt    = io_bus.dir;
            w_locked_nxt = 1'b1;
`ifdef SERIAL_ASM_PARITY_EN
            w_par_nxt    = 1'b0;
`endif
          end
        end
        StData: begin
          w_sr_nxt     = w_sr_shift;
          w_bitcnt_nxt = r_bitcnt + 1'b1;
`ifdef SERIAL_ASM_PARITY_EN
          w_par_nxt    = r_par ^ io_bus.din;
          if (r_bitcnt == BitLast) begin
            w_state_nxt = StParity;
          end
`else
          if (r_bitcnt == BitLast) begin
            w_word_nxt       = w_sr_shift;
            w_word_valid_nxt = 1'b1;
            w_state_nxt      = StHunt;
            w_locked_nxt     = 1'b0;
            w_win_nxt        = '0;
            w_fill_nxt       = '0;
          end
`endif
        end
`ifdef SERIAL_ASM_PARITY_EN
        StParity: begin
          if ((r_par ^ io_bus.din) == 1'b0) begin
            w_word_nxt       = r_sr;
            w_word_valid_nxt = 1'b1;
          end else begin
            w_parity_err_nxt = 1'b1;
          end
          w_state_nxt  = StHunt;
          w_locked_nxt = 1'b0;
          w_win_nxt    = '0;
          w_fill_nxt   = '0;
        end
`endif
        default: begin
          w_state_nxt  = StHunt;
          w_locked_nxt = 1'b0;
          w_win_nxt    = '0;
          w_fill_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StHunt;
      r_win        <= '0;
      r_fill       <= '0;
      r_bitcnt     <= '0;
      r_sr         <= '0;
      r_dir        <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_locked     <= 1'b0;
`ifdef SERIAL_ASM_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_win        <= w_win_nxt;
      r_fill       <= w_fill_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_sr         <= w_sr_nxt;
      r_dir        <= w_dir_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_locked     <= w_locked_nxt;
`ifdef SERIAL_ASM_PARITY_EN
      r_par        <= w_par_nxt;
      r_parity_err <= w_parity_err_nxt;
`endif
    end
  end

  assign io_bus.word_out   = r_word;
  assign io_bus.word_valid = r_word_valid;
  assign io_bus.locked     = r_locked;
`ifdef SERIAL_ASM_PARITY_EN
  assign io_bus.parity_err = r_parity_err;
`else
  assign io_bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler (W=8, sync 1011); follows SERIAL_ASM_PARITY_EN
// so the same stimulus exercises both the parity and the plain build.
module tb_serial_word_assembler;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_wv   = 0;
  int   n_pe   = 0;
  int   n_both = 0;
  int   wv0;

  serial_word_assembler_if #(.W(8)) bus ();

  serial_word_assembler #(
    .W        (8),
    .SYNC_LEN (4),
    .SYNC_PAT (4'b1011)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) n_wv++;
    if (bus.parity_err === 1'b1) n_pe++;
    if (bus.word_valid === 1'b1 && bus.parity_err === 1'b1) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sync 1011 then payload bits pay[7] down to pay[0], then the parity bit when enabled.
  task automatic send_frame(input logic [7:0] pay, input logic pbit, input logic dsync,
                            input bit toggle, input int gap);
    logic [3:0] sync;
    bit         last;
    sync    = 4'b1011;
    bus.dir = dsync;
    for (int i = 0; i < 4; i++) begin
      send_bit(sync[3-i]);
      check((i == 3) ? "lock_on" : "lock_sync", {31'd0, bus.locked}, (i == 3) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      if (toggle) bus.dir = ~bus.dir;
      send_bit(pay[7-i]);
`ifdef SERIAL_ASM_PARITY_EN
      last = 1'b0;
`else
      last = (i == 7);
`endif
      check("lock_data", {31'd0, bus.locked}, last ? 0 : 1);
      if (!last) check("wv_mid", {31'd0, bus.word_valid}, 0);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          idle();
          check("lock_gap", {31'd0, bus.locked}, 1);
        end
      end
    end
`ifdef SERIAL_ASM_PARITY_EN
    send_bit(pbit);
    check("lock_par", {31'd0, bus.locked}, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] part;
    rst           = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    bus.dir       = 1'b0;

    // Reset with active-looking input
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_locked", {31'd0, bus.locked}, 0);
      check("rst_wv", {31'd0, bus.word_valid}, 0);
      check("rst_pe", {31'd0, bus.parity_err}, 0);
      check("rst_word", {24'd0, bus.word_out}, 32'h0);
    end
    @(negedge clk);
    rst           = 1'b0;
    bus.din_valid = 1'b0;

    // MSB-first 0x12
    wv0 = n_wv;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 0);
    check("msb_word", {24'd0, bus.word_out}, 32'h12);
    check("msb_wv", {31'd0, bus.word_valid}, 1);
    check("msb_pe", {31'd0, bus.parity_err}, 0);
    idle();
    check("msb_wv_drop", {31'd0, bus.word_valid}, 0);
    check("msb_wv_count", n_wv - wv0, 1);

    // LSB-first, dir toggled through the payload
    wv0 = n_wv;
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 0);
    check("lsb_word", {24'd0, bus.word_out}, 32'h48);
    check("lsb_wv", {31'd0, bus.word_valid}, 1);
    idle();
    check("lsb_wv_drop", {31'd0, bus.word_valid}, 0);
    check("lsb_wv_count", n_wv - wv0, 1);

    // Leading 0 makes the stream 0,1,0,1,1; 3-cycle gaps inside the payload
    wv0 = n_wv;
    send_bit(1'b0);
    check("fs_nolock", {31'd0, bus.locked}, 0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 3);
    check("gap_word", {24'd0, bus.word_out}, 32'h12);
    check("gap_wv", {31'd0, bus.word_valid}, 1);
    idle();
    check("gap_wv_count", n_wv - wv0, 1);

    // 0xA5 with parity bit 1
    wv0 = n_wv;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
`ifdef SERIAL_ASM_PARITY_EN
    check("perr_pe", {31'd0, bus.parity_err}, 1);
    check("perr_wv", {31'd0, bus.word_valid}, 0);
    check("perr_word", {24'd0, bus.word_out}, 32'h12);
    idle();
    check("perr_pe_drop", {31'd0, bus.parity_err}, 0);
    check("perr_wv_count", n_wv - wv0, 0);
    check("perr_word_hold", {24'd0, bus.word_out}, 32'h12);
`else
    check("a5_word", {24'd0, bus.word_out}, 32'hA5);
    check("a5_wv", {31'd0, bus.word_valid}, 1);
    check("a5_pe", {31'd0, bus.parity_err}, 0);
    idle();
    check("a5_wv_count", n_wv - wv0, 1);
`endif

    // Reset after sync plus 3 payload bits, then a clean 0x3C frame
    part    = 7'b1011_001;
    bus.dir = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(part[6-i]);
    check("mid_locked_pre", {31'd0, bus.locked}, 1);
    wv0 = n_wv;
    @(negedge clk);
    rst           = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    check("mid_locked", {31'd0, bus.locked}, 0);
    check("mid_wv", {31'd0, bus.word_valid}, 0);
    check("mid_pe", {31'd0, bus.parity_err}, 0);
    check("mid_word", {24'd0, bus.word_out}, 32'h0);
    @(negedge clk);
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    check("post_word", {24'd0, bus.word_out}, 32'h3C);
    check("post_wv", {31'd0, bus.word_valid}, 1);
    idle();
    check("post_wv_count", n_wv - wv0, 1);

    check("no_overlap", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_assembler.md
# serial_word_assembler

Downstream consumer of the serial bit stream produced by the bidirectional shift-register stage. It hunts for a fixed sync pattern, assembles the next `W` payload bits into a parallel word in either MSB-first or LSB-first order, and presents the word with a one-cycle valid strobe. An optional even-parity bit is checked per frame.

## Interface
- `W`, default 8: payload word width; minimum 2.
- `SYNC_LEN`, default 4: sync pattern length in bits; minimum 2.
- `SYNC_PAT`, default `4'b1011`: sync pattern; first received bit is the MSB; must be non-zero.

- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  1: serial data bit.
- `din_valid`  in  1: `din` is accepted on an edge only when this is high.
- `dir`  in  1: bit order; 0 = MSB-first, 1 = LSB-first.
- `word_out`  out  `W`: last good assembled word; holds until the next good word.
- `word_valid`  out  1: one-cycle strobe; `word_out` is new.
- `locked`  out  1: high while the frame payload (and parity) is being received.
- `parity_err`  out  1: one-cycle strobe on a parity mismatch.

## Operation
- Reset values: `word_out`=0, `word_valid`=0, `locked`=0, `parity_err`=0, state=HUNT, sync window=0, fill count=0, bit count=0.
- Only edges with `din_valid`=1 advance any state. `word_valid` and `parity_err` drop to 0 on every edge where they are not freshly set.
- **HUNT**:
  - The sync window shifts left: `win <= {win[SYNC_LEN-2:0], din}`.
  - The fill count saturates at `SYNC_LEN`.
  - A match requires a full window: fill count ≥ `SYNC_LEN` after the shift, and the window equals `SYNC_PAT`.
  - On a match: go to DATA, clear the bit count, latch `dir` into `dir_q`, and set `locked`=1.
- **DATA**:
  - If `dir_q`=0, the shift register loads `{sr[W-2:0], din}`.
  - If `dir_q`=1, it loads `{din, sr[W-1:1]}`.
  - A running XOR accumulates the parity.
  - `dir` changes during a frame are ignored.
  - On the W-th bit: go to PARITY if parity is enabled. Otherwise, load `word_out` with the final register value, set `word_valid`=1, and go to HUNT.
- **PARITY** (only with `PARITY_EN`):
  - If the accumulated XOR of the payload XOR `din` is 0, load `word_out` and set `word_valid`=1.
  - Otherwise set `parity_err`=1 and leave `word_out` unchanged.
  - In both cases go to HUNT.
- **Return to HUNT**: clear `locked`, the window, and the fill count. No sync is detected inside payload bits.
- `rst` during any state overrides everything: all registers return to their reset values on that edge.

## Timing
- `locked` rises on the edge that accepts the last sync bit.
- `locked` falls on the edge that accepts the last frame bit (the last data bit, or the parity bit).
- `word_valid` and `parity_err` are registered. They are high for exactly the one cycle following the edge that accepts the last frame bit.
- Gaps in `din_valid` stretch the frame but do not change the result.
- The minimum frame is `SYNC_LEN + W` valid bits, plus 1 with parity enabled.
- A new frame can start on the valid bit immediately after the previous frame.
- `word_valid` and `parity_err` never assert in the same cycle.

## Configuration
- `SERIAL_ASM_PARITY_EN` defined:
  - The PARITY state exists.
  - Each frame carries one trailing even-parity bit.
  - `parity_err` is live.
- Not defined:
  - The PARITY state is removed.
  - A frame is sync plus `W` bits.
  - `parity_err` is tied to 0.

## Test plan
All scenarios use `W`=8 and `SYNC_PAT`=1011. Parity bits apply only to the `SERIAL_ASM_PARITY_EN` build.
- **Reset**: assert `rst` for 2 cycles with `din_valid`=1 and `din`=1. All outputs must stay 0 and `locked`=0.
- **MSB-first frame**: `dir`=0; send bits 1,0,1,1 then 0,0,0,1,0,0,1,0, plus parity bit 0. Required: `word_out`=8'h12, `word_valid` high for exactly one cycle, `locked` high only during the payload.
- **LSB-first frame**: `dir`=1 latched at sync; send the same payload bits 0,0,0,1,0,0,1,0. Required: `word_out`=8'h48. Toggling `dir` mid-payload must not change the result.
- **Gaps and false sync**:
  - Send preceding bits 0,1,0,1,1 (so 1011 matches only at the 5th bit), then the 8'h12 payload.
  - Insert 3 idle cycles (`din_valid`=0) between payload bits.
  - Required: 8'h12 with a single `word_valid`.
- **Parity error**: after the 8'h12 frame, send frame 8'hA5 with parity bit 1. Required: `parity_err` pulses once, `word_valid` stays 0, and `word_out` stays 8'h12.
- **Reset mid-frame**: assert `rst` after 3 payload bits. Required: `locked`=0 and no strobes. A subsequent full 8'h3C frame must decode correctly.
